// File: rtl/matmul_top.sv
// Matrix-multiply accelerator: host-loaded A and B-transposed row buffers,
// one dot product per FETCH/CALC/WRITE pass, results in a 64x64 output buffer.
module matmul_top #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_SIZE = 128
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               en_A_axi,
  input  logic                               we_A_axi,
  input  logic                               en_B_axi,
  input  logic                               we_B_axi,
  input  logic                               en_out_axi,
  input  logic                               we_out_axi,
  input  logic [5:0]                         addr_A_axi,
  input  logic [5:0]                         addr_B_axi,
  input  logic [11:0]                        addr_out_axi,
  input  logic [DATA_WIDTH*ARRAY_SIZE/2-1:0] din_A_axi_MSB,
  input  logic [DATA_WIDTH*ARRAY_SIZE/2-1:0] din_A_axi_LSB,
  input  logic [DATA_WIDTH*ARRAY_SIZE/2-1:0] din_B_axi_MSB,
  input  logic [DATA_WIDTH*ARRAY_SIZE/2-1:0] din_B_axi_LSB,
  output logic [DATA_WIDTH-1:0]              dout_out_axi,
  output logic                               done
);

  localparam int ROW_W = DATA_WIDTH * ARRAY_SIZE;
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(ARRAY_SIZE) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [ROW_W-1:0]      a_mem   [64];
  logic [ROW_W-1:0]      b_mem   [64];
  logic [DATA_WIDTH-1:0] out_mem [4096];

  logic [2:0]            state_q, state_d;
  logic [5:0]            i_q, i_d;
  logic [5:0]            j_q, j_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [ROW_W-1:0]      a_row_q, a_row_d;
  logic [ROW_W-1:0]      b_row_q, b_row_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;

  logic                    host_wr_ok_s;
  logic                    a_we_s;
  logic                    b_we_s;
  logic signed [ACC_W-1:0] dot_s;
  logic                    unused_we_out;

  assign unused_we_out = we_out_axi;

  assign host_wr_ok_s = (state_q == S_IDLE) || (state_q == S_DONE);
  assign a_we_s       = en_A_axi && we_A_axi && host_wr_ok_s;
  assign b_we_s       = en_B_axi && we_B_axi && host_wr_ok_s;

  // Element k sits at the top of the row for k = 0, i.e. bits [ROW_W-1-W*k -: W].
  always_comb begin
    dot_s = '0;
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      dot_s = dot_s + ACC_W'($signed(a_row_q[ROW_W-1-DATA_WIDTH*k -: DATA_WIDTH]) *
                             $signed(b_row_q[ROW_W-1-DATA_WIDTH*k -: DATA_WIDTH]));
    end
  end

  // start is registered before IDLE acts on it; DONE releases on the raw level.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_row_d = a_row_q;
    b_row_d = b_row_q;
    res_d   = res_q;
    start_d = start;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          i_d     = 6'd0;
          j_d     = 6'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        a_row_d = a_mem[i_q];
        b_row_d = b_mem[j_q];
        state_d = S_CALC;
      end
      S_CALC: begin
        res_d   = dot_s[DATA_WIDTH-1:0];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (j_q != 6'd63) begin
          j_d     = j_q + 6'd1;
          state_d = S_FETCH;
        end else if (i_q != 6'd63) begin
          j_d     = 6'd0;
          i_d     = i_q + 6'd1;
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    done_d = (state_d == S_DONE);
    if (en_out_axi) begin
      dout_d = out_mem[addr_out_axi];
    end else begin
      dout_d = dout_q;
    end
  end

  // rst_n is active-high and synchronous.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      i_q     <= 6'd0;
      j_q     <= 6'd0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      start_q <= start_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    a_row_q <= a_row_d;
    b_row_q <= b_row_d;
    res_q   <= res_d;
  end

  // Buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (a_we_s) begin
      a_mem[addr_A_axi] <= {din_A_axi_MSB, din_A_axi_LSB};
    end
    if (b_we_s) begin
      b_mem[addr_B_axi] <= {din_B_axi_MSB, din_B_axi_LSB};
    end
    if (!rst_n && state_q == S_WRITE) begin
      out_mem[{i_q, j_q}] <= res_q;
    end
  end

  assign dout_out_axi = dout_q;
  assign done         = done_q;

endmodule

// File: tb/tb_matmul_top.sv
// Directed + randomized bench for matmul_top; expected results come from a
// plain-arithmetic matrix model kept in the bench.
module tb_matmul_top;

  localparam int W  = 16;
  localparam int K  = 128;
  localparam int HW = W * K / 2;
  localparam int EXP_LAT = 12289;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            en_A_axi = 1'b0, we_A_axi = 1'b0;
  logic            en_B_axi = 1'b0, we_B_axi = 1'b0;
  logic            en_out_axi = 1'b0, we_out_axi = 1'b0;
  logic [5:0]      addr_A_axi = 6'd0, addr_B_axi = 6'd0;
  logic [11:0]     addr_out_axi = 12'd0;
  logic [HW-1:0]   din_A_axi_MSB = '0, din_A_axi_LSB = '0;
  logic [HW-1:0]   din_B_axi_MSB = '0, din_B_axi_LSB = '0;
  logic [W-1:0]    dout_out_axi;
  logic            done;

  int vectors = 0;
  int miscompares = 0;

  logic signed [15:0] a_m [64][128];
  logic signed [15:0] b_m [64][128];

  matmul_top #(.DATA_WIDTH(W), .ARRAY_SIZE(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .en_A_axi(en_A_axi), .we_A_axi(we_A_axi),
    .en_B_axi(en_B_axi), .we_B_axi(we_B_axi),
    .en_out_axi(en_out_axi), .we_out_axi(we_out_axi),
    .addr_A_axi(addr_A_axi), .addr_B_axi(addr_B_axi), .addr_out_axi(addr_out_axi),
    .din_A_axi_MSB(din_A_axi_MSB), .din_A_axi_LSB(din_A_axi_LSB),
    .din_B_axi_MSB(din_B_axi_MSB), .din_B_axi_LSB(din_B_axi_LSB),
    .dout_out_axi(dout_out_axi), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // C[i][j] = sum_k A[i][k]*B[j][k], keep the low 16 bits
  function automatic logic [15:0] ref_c(input int i, input int j);
    longint s;
    s = 0;
    for (int k = 0; k < K; k++) s += longint'(a_m[i][k]) * longint'(b_m[j][k]);
    return s[15:0];
  endfunction

  function automatic logic [2*HW-1:0] pack(input bit is_b, input int r);
    logic [2*HW-1:0] row;
    for (int k = 0; k < K; k++) row[W*(K-k)-1 -: W] = is_b ? b_m[r][k] : a_m[r][k];
    return row;
  endfunction

  task automatic drive_row(input bit is_b, input int r, input logic [2*HW-1:0] row, input bit we);
    if (is_b) begin
      en_B_axi = 1'b1; we_B_axi = we; addr_B_axi = 6'(r);
      din_B_axi_MSB = row[2*HW-1:HW]; din_B_axi_LSB = row[HW-1:0];
    end else begin
      en_A_axi = 1'b1; we_A_axi = we; addr_A_axi = 6'(r);
      din_A_axi_MSB = row[2*HW-1:HW]; din_A_axi_LSB = row[HW-1:0];
    end
    tick();
    en_A_axi = 1'b0; we_A_axi = 1'b0; en_B_axi = 1'b0; we_B_axi = 1'b0;
  endtask

  task automatic load_a();
    for (int r = 0; r < 64; r++) drive_row(1'b0, r, pack(1'b0, r), 1'b1);
  endtask

  task automatic load_b();
    for (int r = 0; r < 64; r++) drive_row(1'b1, r, pack(1'b1, r), 1'b1);
  endtask

  function automatic logic [2*HW-1:0] garbage_row();
    logic [2*HW-1:0] row;
    for (int w = 0; w < 2*HW/32; w++) row[32*w +: 32] = $urandom;
    return row;
  endfunction

  task automatic randomize_a();
    for (int r = 0; r < 64; r++)
      for (int k = 0; k < K; k++) a_m[r][k] = 16'($urandom);
  endtask

  task automatic randomize_b();
    for (int r = 0; r < 64; r++)
      for (int k = 0; k < K; k++) b_m[r][k] = 16'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget, output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < budget) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Raise start, then count cycles from the edge that samples it to done.
  task automatic run_and_time(input string tag);
    int cnt;
    start = 1'b1;
    tick();
    wait_done({tag, "_done"}, EXP_LAT + 100, cnt);
    chk({tag, "_latency"}, 32'(cnt), 32'(EXP_LAT));
  endtask

  task automatic read_chk(input int addr, input logic [15:0] exp);
    en_out_axi = 1'b1;
    addr_out_axi = 12'(addr);
    tick();
    en_out_axi = 1'b0;
    chk($sformatf("c[%0d]", addr), 32'(dout_out_axi), 32'(exp));
  endtask

  task automatic verify_full();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) read_chk(i*64 + j, ref_c(i, j));
  endtask

  // Rows 0..3 in full, some random addresses, then check the read port holds.
  task automatic verify_sample();
    int i, j;
    logic [15:0] last;
    for (int a = 0; a < 256; a++) read_chk(a, ref_c(a / 64, a % 64));
    for (int n = 0; n < 48; n++) begin
      i = $urandom_range(0, 63);
      j = $urandom_range(0, 63);
      read_chk(i*64 + j, ref_c(i, j));
    end
    last = ref_c(i, j);
    addr_out_axi = 12'(((i*64 + j) + 1) % 4096);
    tick();
    chk("dout_hold", 32'(dout_out_axi), 32'(last));
  endtask

  initial begin
    int cnt;
    logic seen;

    // reset
    tick();
    tick();
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dout", 32'(dout_out_axi), 32'd0);
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      tick();
      seen = seen | done;
    end
    chk("idle_done", 32'(seen), 32'd0);

    // identity
    for (int r = 0; r < 64; r++)
      for (int k = 0; k < K; k++) begin
        a_m[r][k] = (k == r) ? 16'sd1 : 16'sd0;
        b_m[r][k] = 16'(r + 1);
      end
    load_a();
    load_b();
    run_and_time("identity");
    tick();
    chk("done_hold", 32'(done), 32'd1);
    read_chk(3*64 + 10, 16'd11);
    verify_full();
    start = 1'b0;
    tick();
    chk("done_drop", 32'(done), 32'd0);

    // signed and wrap, mixed in quadrants
    for (int r = 0; r < 64; r++)
      for (int k = 0; k < K; k++) begin
        a_m[r][k] = (r < 32) ? -16'sd1 : 16'sh0100;
        b_m[r][k] = (r < 32) ? 16'sd2 : 16'sh0100;
      end
    load_a();
    load_b();
    run_and_time("signed");
    read_chk(0, 16'hFF00);
    read_chk(40*64 + 40, 16'h0000);
    read_chk(0*64 + 40, 16'h8000);
    read_chk(40*64 + 0, 16'h0000);
    verify_sample();
    start = 1'b0;
    tick();

    // element order; a write with we=0 must not land
    for (int r = 0; r < 64; r++)
      for (int k = 0; k < K; k++) begin
        a_m[r][k] = 16'sd0;
        b_m[r][k] = 16'sd0;
      end
    a_m[0][0] = 16'sd3;
    b_m[5][0] = 16'sd7;
    load_a();
    load_b();
    drive_row(1'b0, 1, garbage_row(), 1'b0);
    run_and_time("order");
    read_chk(5, 16'd21);
    verify_full();
    start = 1'b0;
    tick();

    // ownership: host writes while busy are ignored
    randomize_a();
    randomize_b();
    load_a();
    load_b();
    start = 1'b1;
    tick();
    repeat (200) tick();
    for (int r = 0; r < 4; r++) drive_row(1'b0, r, garbage_row(), 1'b1);
    drive_row(1'b1, 0, garbage_row(), 1'b1);
    wait_done("own_done", EXP_LAT, cnt);
    verify_sample();
    start = 1'b0;
    tick();
    chk("restart_drop", 32'(done), 32'd0);
    repeat (5) tick();
    chk("no_recompute", 32'(done), 32'd0);

    // reload A, restart, reset at cycle 5000, then run to completion
    randomize_a();
    load_a();
    start = 1'b1;
    tick();
    repeat (5000) tick();
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_dout", 32'(dout_out_axi), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | done;
    end
    chk("midreset_idle", 32'(seen), 32'd0);
    run_and_time("after_reset");
    verify_sample();
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
